// File: rtl/ps2_ctrl_decoder.sv
// PS/2 keyboard receiver and make/break decoder driving held player-control levels.
// Define PS2_WASD_EN to add W/A/S/D as a second, independently held direction source.
module ps2_ctrl_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ctrl_up,
    output logic       ctrl_down,
    output logic       ctrl_left,
    output logic       ctrl_right,
    output logic       ctrl_fire,
    output logic       ctrl_slow,
    output logic [7:0] scan_code,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    localparam int DIR_UP = 0;
    localparam int DIR_DN = 1;
    localparam int DIR_LT = 2;
    localparam int DIR_RT = 3;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Line conditioning: index 0 = ps2_clk, index 1 = ps2_data.
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          filt_q, filt_d;
    logic [1:0][FW-1:0]  fcnt_q, fcnt_d;
    logic                fclk_prev_q;
    logic                bit_evt, bit_dat;

    state_t              state_q, state_d;
    logic [2:0]          bitcnt_q, bitcnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_ok_q, par_ok_d;
    logic [TW-1:0]       to_cnt_q, to_cnt_d;
    logic                byte_rdy_q, byte_rdy_d;
    logic                bad_q, bad_d;
    logic                ferr_q, ferr_d;

    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic [7:0]          scan_q, scan_d;
    logic                kv_q, kv_d;
    logic [3:0]          arrow_q, arrow_d;
    logic                fire_q, fire_d;
    logic                slow_q, slow_d;
    logic [3:0]          wasd_held;
    logic                make;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            fcnt_q      <= '0;
            fclk_prev_q <= 1'b1;
        end else begin
            sync1_q     <= {ps2_data, ps2_clk};
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            fclk_prev_q <= filt_q[0];
        end
    end

    // A filtered level flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_MAX) filt_d[i] = sync2_q[i];
                else                       fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end
    end

    assign bit_evt = fclk_prev_q & ~filt_q[0];
    assign bit_dat = filt_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            to_cnt_q   <= '0;
            byte_rdy_q <= 1'b0;
            bad_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            to_cnt_q   <= to_cnt_d;
            byte_rdy_q <= byte_rdy_d;
            bad_q      <= bad_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        byte_rdy_d = 1'b0;
        bad_d      = 1'b0;
        ferr_d     = 1'b0;
        to_cnt_d   = to_cnt_q + 1'b1;
        if (state_q == IDLE || bit_evt) to_cnt_d = '0;

        case (state_q)
            IDLE: begin
                if (bit_evt && !bit_dat) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                end
            end
            DATA: begin
                if (bit_evt) begin
                    shift_d  = {bit_dat, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (bit_evt) begin
                    par_ok_d = ^{shift_q, bit_dat};
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (bit_evt) begin
                    state_d = IDLE;
                    if (bit_dat && par_ok_q) begin
                        byte_rdy_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                        bad_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled keyboard must not wedge the receiver mid-frame.
        if (state_q != IDLE && !bit_evt && to_cnt_q == TO_MAX) begin
            state_d  = IDLE;
            ferr_d   = 1'b1;
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            scan_q  <= '0;
            kv_q    <= 1'b0;
            arrow_q <= '0;
            fire_q  <= 1'b0;
            slow_q  <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            scan_q  <= scan_d;
            kv_q    <= kv_d;
            arrow_q <= arrow_d;
            fire_q  <= fire_d;
            slow_q  <= slow_d;
        end
    end

`ifdef PS2_WASD_EN
    logic [3:0] wasd_q, wasd_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wasd_q <= '0;
        else       wasd_q <= wasd_d;
    end

    assign wasd_held = wasd_q;
`else
    assign wasd_held = '0;
`endif

    assign make = ~brk_q;

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        scan_d  = scan_q;
        kv_d    = 1'b0;
        arrow_d = arrow_q;
        fire_d  = fire_q;
        slow_d  = slow_q;
`ifdef PS2_WASD_EN
        wasd_d  = wasd_q;
`endif
        // A corrupted frame may have been the key that a pending prefix belonged to.
        if (bad_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
        if (byte_rdy_q) begin
            kv_d   = 1'b1;
            scan_d = shift_q;
            case (shift_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'hE1: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    if (ext_q) begin
                        case (shift_q)
                            8'h75:   arrow_d[DIR_UP] = make;
                            8'h72:   arrow_d[DIR_DN] = make;
                            8'h6B:   arrow_d[DIR_LT] = make;
                            8'h74:   arrow_d[DIR_RT] = make;
                            default: ;
                        endcase
                    end else begin
                        case (shift_q)
                            8'h1A:   fire_d = make;
                            8'h12:   slow_d = make;
`ifdef PS2_WASD_EN
                            8'h1D:   wasd_d[DIR_UP] = make;
                            8'h1B:   wasd_d[DIR_DN] = make;
                            8'h1C:   wasd_d[DIR_LT] = make;
                            8'h23:   wasd_d[DIR_RT] = make;
`endif
                            default: ;
                        endcase
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

    assign ctrl_up    = arrow_q[DIR_UP] | wasd_held[DIR_UP];
    assign ctrl_down  = arrow_q[DIR_DN] | wasd_held[DIR_DN];
    assign ctrl_left  = arrow_q[DIR_LT] | wasd_held[DIR_LT];
    assign ctrl_right = arrow_q[DIR_RT] | wasd_held[DIR_RT];
    assign ctrl_fire  = fire_q;
    assign ctrl_slow  = slow_q;
    assign scan_code  = scan_q;
    assign key_valid  = kv_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_ctrl_decoder.sv
// Directed bench for ps2_ctrl_decoder: table of PS/2 frames with expected held levels,
// plus hand sequences for timeout, glitch rejection and mid-frame reset.
module tb_ps2_ctrl_decoder;

    localparam int FILT = 4;
    localparam int TOUT = 300;
    localparam int HALF = 15;
`ifdef PS2_WASD_EN
    localparam bit WASD = 1'b1;
`else
    localparam bit WASD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ctrl_up, ctrl_down, ctrl_left, ctrl_right, ctrl_fire, ctrl_slow;
    logic [7:0] scan_code;
    logic       key_valid, frame_err;

    ps2_ctrl_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ctrl_up(ctrl_up), .ctrl_down(ctrl_down), .ctrl_left(ctrl_left),
        .ctrl_right(ctrl_right), .ctrl_fire(ctrl_fire), .ctrl_slow(ctrl_slow),
        .scan_code(scan_code), .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // {up, down, left, right, fire, slow}
    wire [5:0] ctrl_vec = {ctrl_up, ctrl_down, ctrl_left, ctrl_right, ctrl_fire, ctrl_slow};

    int cyc = 0, kv_cnt = 0, fe_cnt = 0, kv_cyc = -1, chg_cyc = -1;
    logic [5:0] ctrl_prev = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (key_valid) begin
            kv_cnt = kv_cnt + 1;
            kv_cyc = cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (ctrl_vec !== ctrl_prev) begin
            chg_cyc   = cyc;
            ctrl_prev = ctrl_vec;
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit((~^code) ^ bad_par);
        send_bit(~bad_stop);
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       bad_stop;
        logic [5:0] exp_n;
        logic [5:0] exp_w;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] c, input logic bp, input logic bs,
                       input logic [5:0] en, input logic [5:0] ew);
        vec_t v;
        v.code = c; v.bad_par = bp; v.bad_stop = bs; v.exp_n = en; v.exp_w = ew;
        tbl.push_back(v);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int kv0, fe0;
        logic [5:0] prev_exp, exp;
        logic [7:0] pcode;

        add(8'hE0, 0, 0, 6'b000000, 6'b000000);
        add(8'h75, 0, 0, 6'b100000, 6'b100000);
        add(8'hE0, 0, 0, 6'b100000, 6'b100000);
        add(8'hF0, 0, 0, 6'b100000, 6'b100000);
        add(8'h75, 0, 0, 6'b000000, 6'b000000);
        add(8'h1A, 1, 0, 6'b000000, 6'b000000);
        add(8'h1A, 0, 0, 6'b000010, 6'b000010);
        add(8'h1A, 0, 0, 6'b000010, 6'b000010);
        add(8'hE0, 0, 0, 6'b000010, 6'b000010);
        add(8'h6B, 0, 0, 6'b001010, 6'b001010);
        add(8'hE0, 0, 0, 6'b001010, 6'b001010);
        add(8'hF0, 0, 0, 6'b001010, 6'b001010);
        add(8'h6B, 0, 0, 6'b000010, 6'b000010);
        add(8'h1D, 0, 0, 6'b000010, 6'b100010);
        add(8'hE0, 0, 0, 6'b000010, 6'b100010);
        add(8'h75, 0, 0, 6'b100010, 6'b100010);
        add(8'hF0, 0, 0, 6'b100010, 6'b100010);
        add(8'h1D, 0, 0, 6'b100010, 6'b100010);
        add(8'hE0, 0, 0, 6'b100010, 6'b100010);
        add(8'hF0, 0, 0, 6'b100010, 6'b100010);
        add(8'h75, 0, 0, 6'b000010, 6'b000010);
        add(8'hF0, 0, 0, 6'b000010, 6'b000010);
        add(8'h1A, 0, 0, 6'b000000, 6'b000000);
        add(8'hE0, 0, 0, 6'b000000, 6'b000000);
        add(8'h12, 0, 0, 6'b000000, 6'b000000);
        add(8'hE0, 0, 0, 6'b000000, 6'b000000);
        add(8'h75, 0, 1, 6'b000000, 6'b000000);
        add(8'h75, 0, 0, 6'b000000, 6'b000000);
        add(8'hE0, 0, 0, 6'b000000, 6'b000000);
        add(8'hE1, 0, 0, 6'b000000, 6'b000000);
        add(8'h75, 0, 0, 6'b000000, 6'b000000);
        add(8'h1B, 0, 0, 6'b000000, 6'b010000);
        add(8'hF0, 0, 0, 6'b000000, 6'b010000);
        add(8'h1B, 0, 0, 6'b000000, 6'b000000);
        add(8'hE0, 0, 0, 6'b000000, 6'b000000);
        add(8'h72, 0, 0, 6'b010000, 6'b010000);
        add(8'hE0, 0, 0, 6'b010000, 6'b010000);
        add(8'h74, 0, 0, 6'b010100, 6'b010100);
        add(8'hE0, 0, 0, 6'b010100, 6'b010100);
        add(8'hF0, 0, 0, 6'b010100, 6'b010100);
        add(8'h72, 0, 0, 6'b000100, 6'b000100);
        add(8'hE0, 0, 0, 6'b000100, 6'b000100);
        add(8'hF0, 0, 0, 6'b000100, 6'b000100);
        add(8'h74, 0, 0, 6'b000000, 6'b000000);

        repeat (3) @(negedge clk);
        chk("reset ctrl", 32'(ctrl_vec), 32'd0);
        chk("reset scan_code", 32'(scan_code), 32'd0);
        chk("reset key_valid", 32'(key_valid), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        prev_exp = '0;
        foreach (tbl[i]) begin
            kv0 = kv_cnt;
            fe0 = fe_cnt;
            send_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop);
            exp = WASD ? tbl[i].exp_w : tbl[i].exp_n;
            chk($sformatf("row%0d ctrl", i), 32'(ctrl_vec), 32'(exp));
            if (tbl[i].bad_par || tbl[i].bad_stop) begin
                chk($sformatf("row%0d key_valid count", i), 32'(kv_cnt - kv0), 32'd0);
                chk($sformatf("row%0d frame_err count", i), 32'(fe_cnt - fe0), 32'd1);
            end else begin
                chk($sformatf("row%0d key_valid count", i), 32'(kv_cnt - kv0), 32'd1);
                chk($sformatf("row%0d frame_err count", i), 32'(fe_cnt - fe0), 32'd0);
                chk($sformatf("row%0d scan_code", i), 32'(scan_code), 32'(tbl[i].code));
            end
            if (exp != prev_exp)
                chk($sformatf("row%0d ctrl/key_valid cycle", i), 32'(chg_cyc), 32'(kv_cyc));
            if (i == 4) chk("key_valid total after up make/break", 32'(kv_cnt), 32'd5);
            prev_exp = exp;
        end

        // Partial frame then silence: exactly one abort error.
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TOUT + 60) @(negedge clk);
        chk("timeout frame_err count", 32'(fe_cnt - fe0), 32'd1);
        chk("timeout key_valid count", 32'(kv_cnt - kv0), 32'd0);
        send_frame(8'h12, 0, 0);
        chk("slow after timeout", 32'(ctrl_vec), 32'b000001);
        chk("timeout no extra frame_err", 32'(fe_cnt - fe0), 32'd1);

        // Short ps2_clk glitches with data low must not start a frame.
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        ps2_data = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        #1;
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILT - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_data = 1'b1;
        send_frame(8'h1A, 0, 0);
        chk("glitch then fire ctrl", 32'(ctrl_vec), 32'b000011);
        chk("glitch frame_err count", 32'(fe_cnt - fe0), 32'd0);
        chk("glitch key_valid count", 32'(kv_cnt - kv0), 32'd1);

        // Reset in the middle of data bit 5 with right held.
        send_frame(8'hE0, 0, 0);
        send_frame(8'h74, 0, 0);
        chk("right held before reset", 32'(ctrl_vec), 32'b000111);
        pcode = 8'h5A;
        send_bit(1'b0);
        for (int b = 0; b < 4; b++) send_bit(pcode[b]);
        ps2_data = pcode[4];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        fe0 = fe_cnt;
        reset = 1'b1;
        #1;
        chk("mid-frame reset ctrl", 32'(ctrl_vec), 32'd0);
        chk("mid-frame reset scan_code", 32'(scan_code), 32'd0);
        chk("mid-frame reset key_valid", 32'(key_valid), 32'd0);
        chk("mid-frame reset frame_err", 32'(frame_err), 32'd0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (TOUT + 60) @(negedge clk);
        chk("no frame_err after reset", 32'(fe_cnt - fe0), 32'd0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h74, 0, 0);
        chk("right after reset", 32'(ctrl_vec), 32'b000100);
        chk("scan_code after reset", 32'(scan_code), 32'h74);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_ctrl_decoder.md
Name: ps2_ctrl_decoder

Overview:
- PS/2 keyboard receiver and make/break decoder; the source end of the player control interface.
- Turns the raw PS/2 clock/data lines into level-held ctrl_up/down/left/right plus fire and slow-mode levels.
- Outputs feed player and shot logic directly. All outputs are synchronous to clk.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronized samples required before the filtered ps2_clk/ps2_data level changes.
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered ps2_clk falling edge before a partial frame is aborted (1 ms at 100 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous
- ps2_data  input  1  raw PS/2 data from keyboard, asynchronous
- ctrl_up  output  1  high while up is held
- ctrl_down  output  1  high while down is held
- ctrl_left  output  1  high while left is held
- ctrl_right  output  1  high while right is held
- ctrl_fire  output  1  high while Z is held
- ctrl_slow  output  1  high while left Shift is held
- scan_code  output  8  last accepted byte
- key_valid  output  1  one-cycle pulse when scan_code updates
- frame_err  output  1  one-cycle pulse on a rejected or aborted frame

Behaviour:
- Reset (async, active-high):
  - All outputs 0, FSM in IDLE, ext/brk flags 0, filters preset to 1, timeout counter 0.
  - Reset mid-frame discards the partial frame with no frame_err.
- Input conditioning:
  - 2-FF synchronizer on each line, then a FILTER_LEN-sample glitch filter.
  - The bit event is a filtered ps2_clk 1->0 transition; filtered ps2_data is sampled in that same cycle.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE, one transition per bit event.
  - IDLE: bit event with data=0 (start) -> DATA, bit count 0. A start bit of 1 is ignored; stay in IDLE, no error.
  - DATA: shift 8 bits, LSB first; after the 8th bit -> PARITY.
  - PARITY: odd parity over the 8 data bits plus the parity bit.
  - STOP: stop bit must be 1.
  - On a good frame, the byte is accepted in the cycle after the stop event.
  - On a parity or stop failure: frame_err pulse, byte dropped, ext/brk cleared.
- Timeout:
  - Counter clears on every bit event and while in IDLE.
  - Reaching TIMEOUT_CYCLES in any non-IDLE state -> IDLE, one frame_err pulse.
- Byte decode, on each accepted byte:
  - key_valid pulses and scan_code loads, including prefix bytes.
  - E0: set ext. F0: set brk. E1: clear both flags; no key effect.
  - Any other byte: look up (ext, byte). A match sets the key's held bit if brk=0 and clears it if brk=1. Then clear ext and brk.
- Key map:
  - ext 75 = up, ext 72 = down, ext 6B = left, ext 74 = right.
  - non-ext 1A = fire (Z), non-ext 12 = slow (left Shift).
  - ext 12 (print-screen fake shift) is ignored.
  - Unmapped codes only produce key_valid.
- Typematic repeat: repeated make codes leave the held bit at 1; idempotent.
- Simultaneous keys are independent; opposite directions may both be high. Arbitration is the consumer's job.
- Output latency: ctrl_* changes exactly 2 clk cycles after the stop-bit event (one cycle to accept the byte, one to update the register), aligned with the key_valid pulse.

Optional Feature:
- Macro: PS2_WASD_EN.
- Defined: non-ext 1D (W) = up, 1B (S) = down, 1C (A) = left, 23 (D) = right.
  - Separate held bits per source; ctrl_up = arrow_up | w_held, and likewise for the other directions.
  - Releasing one source does not clear the other.
- Undefined: these four codes are unmapped; key_valid only.

Test Plan:
- Frames E0, 75 (good parity) -> ctrl_up=1 two cycles after the second stop bit. Then E0, F0, 75 -> ctrl_up=0. key_valid pulses 5 times total.
- Frame 1A with a wrong parity bit -> frame_err pulse, no key_valid, ctrl_fire stays 0. Then a good 1A -> ctrl_fire=1.
- Send start bit + 4 data bits, then stop toggling ps2_clk for TIMEOUT_CYCLES -> exactly one frame_err. Then a full good 12 frame -> ctrl_slow=1.
- Hold E0 6B and 1A together, then E0 F0 6B -> ctrl_left=0, ctrl_fire=1. A 1 ns glitch on ps2_clk shorter than FILTER_LEN cycles causes no bit event.
- Assert reset during bit 5 of a frame with ctrl_right=1 -> all outputs 0 immediately and no frame_err. The next good E0 74 -> ctrl_right=1.
- With PS2_WASD_EN: press 1D and E0 75, release 1D -> ctrl_up stays 1. Release E0 75 -> ctrl_up=0. Without the macro, 1D gives key_valid only and ctrl_up stays 0.
